// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and defaults for the keypad scanner.
//   scan_state_t   : scanner FSM state encoding
//   DEF_*          : default parameter values used by keypad_scanner
//   hex_legend()   : maps a 4x4 key code (row*4+col) to its printed hex legend
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_t;

  localparam int DEF_NROWS       = 4;
  localparam int DEF_NCOLS       = 4;
  localparam int DEF_DIV_W       = 17;
  localparam int DEF_DEBOUNCE    = 4;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_REPEAT_DLY  = 32;
  localparam int DEF_REPEAT_RATE = 8;

  // Legend layout, row 0 first: C D E F / 3 6 9 B / 2 5 8 0 / 1 4 7 A
  function automatic logic [3:0] hex_legend(input logic [3:0] code);
    logic [3:0] leg;
    case (code)
      4'd0:  leg = 4'hC;
      4'd1:  leg = 4'hD;
      4'd2:  leg = 4'hE;
      4'd3:  leg = 4'hF;
      4'd4:  leg = 4'h3;
      4'd5:  leg = 4'h6;
      4'd6:  leg = 4'h9;
      4'd7:  leg = 4'hB;
      4'd8:  leg = 4'h2;
      4'd9:  leg = 4'h5;
      4'd10: leg = 4'h8;
      4'd11: leg = 4'h0;
      4'd12: leg = 4'h1;
      4'd13: leg = 4'h4;
      4'd14: leg = 4'h7;
      default: leg = 4'hA;
    endcase
    return leg;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo: first-word-fall-through queue of key codes.
//   clk, reset          : clock, asynchronous active-high reset
//   in_data/in_valid/in_ready    : write side
//   out_data/out_valid/out_ready : read side (out_data is head of queue)
// Handshake: a word moves on a clk edge where valid && ready on that side.
// valid never depends on ready; in_ready is also high when full if the head
// is being popped in the same cycle, so a push and pop on a full queue both
// take effect. out_data reads as zero while empty. DEPTH must be a power of 2,
// at least 2.
module key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = !empty;
  assign in_ready  = !full || out_ready;
  assign do_push   = in_valid && in_ready;
  assign do_pop    = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans an NROWS x NCOLS key matrix, debounces presses and
// releases, and queues one key code per accepted press.
//   clk, reset : clock, asynchronous active-high reset
//   rows       : active-low row sense (pulled up externally)
//   cols       : active-low one-cold column drive
//   key_code   : head-of-queue code, row*NCOLS+col
//   key_valid  : queue non-empty
//   key_ready  : consumer takes key_code on key_valid && key_ready
//   overflow   : sticky, a press was dropped on a full queue
//   ovf_clr    : synchronous clear of overflow (a same-cycle drop wins)
// Optional build macro KEYPAD_SCANNER_REPEAT_EN adds auto-repeat of a held
// key (REPEAT_DLY ticks to first repeat, then every REPEAT_RATE ticks).
// DEBOUNCE must be at least 2.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NROWS      = DEF_NROWS,
  parameter int NCOLS      = DEF_NCOLS,
  parameter int DIV_W      = DEF_DIV_W,
  parameter int DEBOUNCE   = DEF_DEBOUNCE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
`ifdef KEYPAD_SCANNER_REPEAT_EN
  parameter int REPEAT_DLY  = DEF_REPEAT_DLY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE,
`endif
  localparam int KW = $clog2(NROWS * NCOLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NROWS-1:0] rows,
  output logic [NCOLS-1:0] cols,
  output logic [KW-1:0]    key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int CW  = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int RW  = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int DCW = $clog2(DEBOUNCE + 1);

  logic [NROWS-1:0] rows_meta;
  logic [NROWS-1:0] rows_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  scan_state_t      state;
  logic [CW-1:0]    col_idx;
  logic [CW-1:0]    col_next;
  logic [RW-1:0]    row_lat;
  logic [RW-1:0]    low_row;
  logic [DCW-1:0]   deb_cnt;
  logic             any_low;
  logic [KW-1:0]    cur_code;
  logic             push_valid;
  logic [KW-1:0]    push_code;
  logic             fifo_in_ready;

`ifdef KEYPAD_SCANNER_REPEAT_EN
  localparam int RPMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RPW   = $clog2(RPMAX + 1);
  logic [RPW-1:0] rpt_cnt;
`endif

  // Two-flop synchronizer; idle (no key) value is all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_meta <= '1;
      rows_s    <= '1;
    end else begin
      rows_meta <= rows;
      rows_s    <= rows_meta;
    end
  end

  // Free-running divider; tick fires once per 2^DIV_W cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= div_cnt + 1'b1;
  end
  assign tick = &div_cnt;

  assign any_low  = ~&rows_s;
  assign col_next = (col_idx == CW'(NCOLS - 1)) ? '0 : col_idx + 1'b1;
  assign cur_code = KW'(int'(row_lat) * NCOLS + int'(col_idx));
  assign cols     = ~(NCOLS'(1) << col_idx);

  // Lowest-index low row wins when several rows are low together.
  always_comb begin
    low_row = '0;
    for (int r = NROWS - 1; r >= 0; r--) begin
      if (!rows_s[r]) low_row = RW'(r);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_SCAN;
      col_idx    <= '0;
      row_lat    <= '0;
      deb_cnt    <= '0;
      push_valid <= 1'b0;
      push_code  <= '0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
      rpt_cnt    <= '0;
`endif
    end else begin
      push_valid <= 1'b0;
      if (tick) begin
        unique case (state)
          ST_SCAN: begin
            if (!any_low) begin
              col_idx <= col_next;
            end else begin
              row_lat <= low_row;
              deb_cnt <= DCW'(1);
              state   <= ST_DEBOUNCE;
            end
          end
          ST_DEBOUNCE: begin
            if (!rows_s[row_lat]) begin
              deb_cnt <= deb_cnt + 1'b1;
              if (deb_cnt == DCW'(DEBOUNCE - 1)) begin
                push_valid <= 1'b1;
                push_code  <= cur_code;
                state      <= ST_HELD;
`ifdef KEYPAD_SCANNER_REPEAT_EN
                rpt_cnt    <= RPW'(REPEAT_DLY);
`endif
              end
            end else begin
              state <= ST_SCAN;
            end
          end
          ST_HELD: begin
            if (!any_low) begin
              deb_cnt <= DCW'(1);
              state   <= ST_RELEASE;
            end
`ifdef KEYPAD_SCANNER_REPEAT_EN
            else if (rpt_cnt == RPW'(1)) begin
              push_valid <= 1'b1;
              push_code  <= cur_code;
              rpt_cnt    <= RPW'(REPEAT_RATE);
            end else begin
              rpt_cnt <= rpt_cnt - 1'b1;
            end
`endif
          end
          ST_RELEASE: begin
            if (any_low) begin
              state <= ST_HELD;
`ifdef KEYPAD_SCANNER_REPEAT_EN
              rpt_cnt <= RPW'(REPEAT_DLY);
`endif
            end else if (deb_cnt == DCW'(DEBOUNCE - 1)) begin
              deb_cnt <= '0;
              col_idx <= col_next;
              state   <= ST_SCAN;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
          default: state <= ST_SCAN;
        endcase
      end
    end
  end

  // A drop that coincides with ovf_clr keeps overflow set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            overflow <= 1'b0;
    else if (push_valid && !fifo_in_ready) overflow <= 1'b1;
    else if (ovf_clr)                     overflow <= 1'b0;
  end

  key_fifo #(
    .WIDTH (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_data   (push_code),
    .in_valid  (push_valid),
    .in_ready  (fifo_in_ready),
    .out_data  (key_code),
    .out_valid (key_valid),
    .out_ready (key_ready)
  );

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001: Parameter NROWS, default 4, number of matrix rows.
REQ-002: Parameter NCOLS, default 4, number of matrix columns.
REQ-003: Parameter DIV_W, default 17, scan-tick divider width; one tick every 2^DIV_W clk cycles.
REQ-004: Parameter DEBOUNCE, default 4, consecutive ticks required for press/release acceptance.
REQ-005: Parameter FIFO_DEPTH, default 4 (power of 2), key-code queue depth.
REQ-006: clk  input  1  single system clock.
REQ-007: reset  input  1  asynchronous, active-high reset.
REQ-008: rows  input  NROWS  active-low row sense, externally pulled up.
REQ-009: cols  output  NCOLS  active-low one-cold column drive.
REQ-010: key_code  output  KW=$clog2(NROWS*NCOLS)  head-of-queue code = row*NCOLS+col.
REQ-011: key_valid  output  1  queue non-empty; key_code is valid.
REQ-012: key_ready  input  1  consumer accepts key_code when key_valid&&key_ready at clk edge.
REQ-013: overflow  output  1  sticky, set when a press is dropped because the queue is full.
REQ-014: ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-015: Divider counter runs free on clk; all scan FSM activity advances only on tick cycles.
REQ-016: FSM states are SCAN, DEBOUNCE, HELD and RELEASE.
REQ-017: SCAN: on a tick with rows all-high, active column index advances by 1 and wraps from NCOLS-1 to 0.
REQ-018: SCAN: on a tick with any row low, column is frozen, lowest-index low row is latched, debounce count = 1, next state DEBOUNCE.
REQ-019: DEBOUNCE: on a tick with the latched row still low, count increments; at count==DEBOUNCE, code is pushed and next state is HELD.
REQ-020: DEBOUNCE: on a tick with the latched row high, no push occurs and next state is SCAN with the column unchanged.
REQ-021: HELD: column stays frozen; on a tick with rows all-high, next state is RELEASE with count = 1.
REQ-022: RELEASE: DEBOUNCE consecutive all-high ticks return the FSM to SCAN with the column advanced; any low row returns it to HELD.
REQ-023: Exactly one push per accepted press; a held key produces no further pushes (see REQ-031).
REQ-024: Queue is FWFT; key_code is stable while key_valid && !key_ready.
REQ-025: Push on full drops the new code and sets overflow; simultaneous push and pop on full is legal and does not drop.
REQ-026: Pop on empty is ignored.
REQ-027: ovf_clr and an overflow-setting event in the same cycle leave overflow set.
REQ-028: rows is passed through a 2-flop synchronizer before use.

Reset
REQ-029: On reset: state=SCAN, column index 0 (cols = all-ones except bit 0 low), divider 0, debounce count 0, queue empty.
REQ-030: On reset: key_valid=0, key_code=0, overflow=0; reset mid-press discards the press and flushes the queue.

Configuration
REQ-031: KEYPAD_SCANNER_REPEAT_EN defined: in HELD, the held code is re-pushed after REPEAT_DLY ticks (default 32), then every REPEAT_RATE ticks (default 8), subject to REQ-025.
REQ-032: KEYPAD_SCANNER_REPEAT_EN undefined: no repeat logic or parameters exist; behaviour is exactly REQ-023.

Structure
REQ-033: Package keypad_pkg holds the FSM state enum, the default parameter constants, and a function mapping code to the 4x4 hex legend (C,D,E,F / 3,6,9,B / 2,5,8,0 / 1,4,7,A).
REQ-034: The queue is sub-module key_fifo (WIDTH, DEPTH parameters; valid/ready both sides); the divider and FSM are inline.

Verification (DIV_W=2, DEBOUNCE=3, FIFO_DEPTH=4)
REQ-035: Press row1 while col2 is active, held 5 ticks -> exactly one key_code=6, key_valid=1 after the 3rd tick.
REQ-036: 1-tick glitch on row0 -> no push; column resumes advancing and wraps 3->0.
REQ-037: Rows 1 and 3 low together on col0 -> key_code=4 (lowest row wins).
REQ-038: 5 presses with key_ready=0 -> 4 codes queued in order, overflow=1; ovf_clr -> overflow=0; pops return the codes in FIFO order.
REQ-039: Reset asserted during DEBOUNCE -> cols=4'b1110, key_valid=0, and no push after release.
REQ-040: With REPEAT_EN and REPEAT_DLY=4, REPEAT_RATE=2, key held 10 ticks -> initial push then repeats at HELD ticks 4, 6, 8, 10.
